// File: rtl/alu_opseq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_opseq_ctrl
// Operand-path sequencer for the EX stage. It accepts one ALU operation per
// request handshake. It then drives the shared X/Y invert muxes, the carry-in
// and the function select of an external, purely combinational ALU for one or
// two passes. It registers the ALU result and returns it on a response
// handshake.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/req_x/req_y         opcode and operands
//                              (0 ADD,1 SUB,2 AND,3 OR,4 NOR,5 NAND,6 ANDN,
//                               7 ABS,8 MIN,9 MAX,10-15 illegal)
//   alu_x/alu_y                operands presented to the ALU invert muxes
//   inv_x/inv_y                invert-mux selects (1 = complement)
//   alu_cin                    adder carry-in
//   alu_fn                     00 ADD, 01 AND, 10 OR
//   alu_res/alu_v              combinational ALU result and signed overflow
//   res_valid/res_ready        response handshake
//   res_data/res_v/res_err     result, overflow flag, illegal-opcode flag
// -----------------------------------------------------------------------------
module alu_opseq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             inv_x,
    output logic             inv_y,
    output logic             alu_cin,
    output logic [1:0]       alu_fn,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_v,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_v,
    output logic             res_err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_ANDN = 4'd6;
    localparam logic [3:0] OP_ABS  = 4'd7;
    localparam logic [3:0] OP_MIN  = 4'd8;
    localparam logic [3:0] OP_MAX  = 4'd9;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_AND = 2'b01;
    localparam logic [1:0] FN_OR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Datapath control word. It is loaded on the edge that enters a pass, so
    // the ALU sees registered controls for the whole pass.
    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             inv_x;
        logic             inv_y;
        logic             cin;
        logic [1:0]       fn;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '{x: {WIDTH{1'b0}}, y: {WIDTH{1'b0}},
                                    inv_x: 1'b0, inv_y: 1'b0, cin: 1'b0,
                                    fn: 2'b00};

    // First-pass control decode for a freshly accepted op.
    function automatic ctrl_t p1_ctrl(input logic [3:0] op,
                                      input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
        ctrl_t c;
        c   = CTRL_ZERO;
        c.x = x;
        c.y = y;
        case (op)
            OP_ADD:  c.fn = FN_ADD;
            OP_SUB,
            OP_MIN,
            OP_MAX:  begin
                // X + ~Y + 1: the subtract result also drives the signed compare
                c.fn    = FN_ADD;
                c.inv_y = 1'b1;
                c.cin   = 1'b1;
            end
            OP_AND:  c.fn = FN_AND;
            OP_OR:   c.fn = FN_OR;
            OP_NOR:  begin
                // ~X & ~Y == ~(X | Y)
                c.fn    = FN_AND;
                c.inv_x = 1'b1;
                c.inv_y = 1'b1;
            end
            OP_NAND: begin
                // ~X | ~Y == ~(X & Y)
                c.fn    = FN_OR;
                c.inv_x = 1'b1;
                c.inv_y = 1'b1;
            end
            OP_ANDN: begin
                c.fn    = FN_AND;
                c.inv_y = 1'b1;
            end
            OP_ABS:  begin
                // Pass X through the adder; the sign is inspected at pass end
                c.fn = FN_ADD;
                c.y  = {WIDTH{1'b0}};
            end
            default: c = CTRL_ZERO;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             req_ready_q, req_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_v_q, res_v_d;
    logic             res_err_q, res_err_d;

    logic             lt_s;
    logic [WIDTH-1:0] sel_s;

    // Signed X<Y from the subtract pass, and the MIN/MAX winner it selects.
    always_comb begin
        lt_s = alu_res[WIDTH-1] ^ alu_v;
        if (op_q == OP_MIN) begin
            sel_s = lt_s ? x_q : y_q;
        end else begin
            sel_s = lt_s ? y_q : x_q;
        end
    end

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        ctrl_d      = CTRL_ZERO;
        req_ready_d = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_v_d     = res_v_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_P1;
                    op_d    = req_op;
                    x_d     = req_x;
                    y_d     = req_y;
                    ctrl_d  = p1_ctrl(req_op, req_x, req_y);
                end else begin
                    req_ready_d = 1'b1;
                end
            end

            ST_P1: begin
                state_d     = ST_DONE;
                res_valid_d = 1'b1;
                res_err_d   = 1'b0;
                res_v_d     = 1'b0;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        res_data_d = alu_res;
                        res_v_d    = alu_v;
                    end
                    OP_AND, OP_OR, OP_NOR, OP_NAND, OP_ANDN: begin
                        res_data_d = alu_res;
                    end
                    OP_ABS: begin
                        if (x_q[WIDTH-1] == 1'b0) begin
                            res_data_d = x_q;
                        end else begin
                            // Negative: second pass forms ~X + 1
                            state_d      = ST_P2;
                            res_valid_d  = 1'b0;
                            ctrl_d.fn    = FN_ADD;
                            ctrl_d.x     = x_q;
                            ctrl_d.inv_x = 1'b1;
                            ctrl_d.cin   = 1'b1;
                        end
                    end
                    OP_MIN, OP_MAX: begin
                        // Second pass routes the winner through the adder
                        state_d     = ST_P2;
                        res_valid_d = 1'b0;
                        ctrl_d.fn   = FN_ADD;
                        ctrl_d.x    = sel_s;
                    end
                    default: begin
                        res_data_d = {WIDTH{1'b0}};
                        res_err_d  = 1'b1;
                    end
                endcase
            end

            ST_P2: begin
                state_d     = ST_DONE;
                res_valid_d = 1'b1;
                res_data_d  = alu_res;
                if (op_q == OP_ABS) begin
                    res_v_d = alu_v;
                end else begin
                    res_v_d = 1'b0;
                end
            end

            ST_DONE: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                end else begin
                    req_ready_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                res_valid_d = 1'b0;
                res_err_d   = 1'b0;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'd0;
            x_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            ctrl_q      <= CTRL_ZERO;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= {WIDTH{1'b0}};
            res_v_q     <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ctrl_q      <= ctrl_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_v_q     <= res_v_d;
            res_err_q   <= res_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign alu_x     = ctrl_q.x;
    assign alu_y     = ctrl_q.y;
    assign inv_x     = ctrl_q.inv_x;
    assign inv_y     = ctrl_q.inv_y;
    assign alu_cin   = ctrl_q.cin;
    assign alu_fn    = ctrl_q.fn;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_v     = res_v_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_opseq_ctrl.sv
module tb_alu_opseq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        inv_x;
    logic        inv_y;
    logic        alu_cin;
    logic [1:0]  alu_fn;
    logic [15:0] alu_res;
    logic        alu_v;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_v;
    logic        res_err;

    int checks   = 0;
    int failures = 0;

    alu_opseq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .alu_x(alu_x), .alu_y(alu_y), .inv_x(inv_x), .inv_y(inv_y),
        .alu_cin(alu_cin), .alu_fn(alu_fn), .alu_res(alu_res), .alu_v(alu_v),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_v(res_v), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU model: invert muxes, adder/AND/OR, signed overflow.
    logic [15:0] ax, ay, sum;
    always_comb begin
        ax      = inv_x ? ~alu_x : alu_x;
        ay      = inv_y ? ~alu_y : alu_y;
        sum     = ax + ay + {15'd0, alu_cin};
        alu_v   = 1'b0;
        alu_res = 16'd0;
        case (alu_fn)
            2'b00: begin
                alu_res = sum;
                alu_v   = (ax[15] == ay[15]) && (sum[15] != ax[15]);
            end
            2'b01:   alu_res = ax & ay;
            2'b10:   alu_res = ax | ay;
            default: alu_res = 16'd0;
        endcase
    end

    // Waits (bounded) for req_ready at a falling edge, then presents one request
    // across the next rising edge.
    task automatic accept(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic release_res();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_x = 16'd0; req_y = 16'd0;
        res_ready = 1'b0;
        #12;
        checks++;
        if ({req_ready, res_valid, res_err, res_v, res_data, alu_x, alu_y, inv_x, inv_y, alu_cin, alu_fn} !== {1'b1, 56'd0}) begin
            failures++;
            $display("FAIL reset_outputs: req_ready=%b res_valid=%b res_data=%h alu_x=%h alu_fn=%b required ready=1 rest 0",
                     req_ready, res_valid, res_data, alu_x, alu_fn);
        end
        @(negedge clk); rst_n = 1'b1;
        // res_ready with nothing pending is ignored
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_res_ready: res_valid=%b req_ready=%b required 0/1", res_valid, req_ready);
        end
    endtask

    task automatic test_add();
        accept(4'd0, 16'h7FFF, 16'h0001);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || res_valid !== 1'b0 || alu_fn !== 2'b00 || inv_x !== 1'b0 || inv_y !== 1'b0 || alu_cin !== 1'b0) begin
            failures++;
            $display("FAIL add_p1: ready=%b valid=%b fn=%b inv=%b%b cin=%b required 0 0 00 00 0",
                     req_ready, res_valid, alu_fn, inv_x, inv_y, alu_cin);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h8000 || res_v !== 1'b1 || res_err !== 1'b0) begin
            failures++;
            $display("FAIL add_result: valid=%b data=%h v=%b err=%b required 1 8000 1 0", res_valid, res_data, res_v, res_err);
        end
        release_res();
    endtask

    task automatic test_sub_nor();
        accept(4'd1, 16'h0005, 16'h0007);
        @(negedge clk);
        checks++;
        if (inv_y !== 1'b1 || alu_cin !== 1'b1 || inv_x !== 1'b0 || alu_fn !== 2'b00) begin
            failures++;
            $display("FAIL sub_p1: inv_x=%b inv_y=%b cin=%b fn=%b required 0 1 1 00", inv_x, inv_y, alu_cin, alu_fn);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'hFFFE || res_v !== 1'b0) begin
            failures++;
            $display("FAIL sub_result: valid=%b data=%h v=%b required 1 fffe 0", res_valid, res_data, res_v);
        end
        release_res();
        accept(4'd4, 16'h00F0, 16'h0F00);
        @(negedge clk);
        checks++;
        if (inv_x !== 1'b1 || inv_y !== 1'b1 || alu_fn !== 2'b01) begin
            failures++;
            $display("FAIL nor_p1: inv_x=%b inv_y=%b fn=%b required 1 1 01", inv_x, inv_y, alu_fn);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'hF00F || res_v !== 1'b0) begin
            failures++;
            $display("FAIL nor_result: valid=%b data=%h v=%b required 1 f00f 0", res_valid, res_data, res_v);
        end
        release_res();
    endtask

    task automatic test_abs();
        accept(4'd7, 16'hFFFB, 16'h1234);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || alu_y !== 16'h0000 || alu_fn !== 2'b00 || alu_x !== 16'hFFFB) begin
            failures++;
            $display("FAIL abs_p1: valid=%b alu_x=%h alu_y=%h fn=%b required 0 fffb 0000 00", res_valid, alu_x, alu_y, alu_fn);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || inv_x !== 1'b1 || alu_cin !== 1'b1 || alu_x !== 16'hFFFB || alu_y !== 16'h0000 || inv_y !== 1'b0) begin
            failures++;
            $display("FAIL abs_p2: valid=%b inv_x=%b cin=%b alu_x=%h alu_y=%h required 0 1 1 fffb 0000",
                     res_valid, inv_x, alu_cin, alu_x, alu_y);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0005 || res_v !== 1'b0) begin
            failures++;
            $display("FAIL abs_neg_result: valid=%b data=%h v=%b required 1 0005 0", res_valid, res_data, res_v);
        end
        release_res();
        accept(4'd7, 16'h8000, 16'h0000);
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL abs_min_early: valid=%b required 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h8000 || res_v !== 1'b1) begin
            failures++;
            $display("FAIL abs_8000_result: valid=%b data=%h v=%b required 1 8000 1", res_valid, res_data, res_v);
        end
        release_res();
        // Non-negative operand finishes in one pass
        accept(4'd7, 16'h0042, 16'hFFFF);
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h0042 || res_v !== 1'b0) begin
            failures++;
            $display("FAIL abs_pos_result: valid=%b data=%h v=%b required 1 0042 0", res_valid, res_data, res_v);
        end
        release_res();
    endtask

    task automatic test_minmax();
        logic [3:0]  ops  [3] = '{4'd8, 4'd9, 4'd9};
        logic [15:0] xs   [3] = '{16'h8000, 16'h8000, 16'h0003};
        logic [15:0] ys   [3] = '{16'h0001, 16'h0001, 16'h0003};
        logic [15:0] exps [3] = '{16'h8000, 16'h0001, 16'h0003};
        for (int i = 0; i < 3; i++) begin
            accept(ops[i], xs[i], ys[i]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || alu_x !== exps[i] || alu_y !== 16'h0000 || inv_x !== 1'b0 || alu_cin !== 1'b0) begin
                failures++;
                $display("FAIL minmax_p2[%0d]: valid=%b alu_x=%h alu_y=%h inv_x=%b cin=%b required 0 %h 0000 0 0",
                         i, res_valid, alu_x, alu_y, inv_x, alu_cin, exps[i]);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exps[i] || res_v !== 1'b0) begin
                failures++;
                $display("FAIL minmax_result[%0d]: valid=%b data=%h v=%b required 1 %h 0", i, res_valid, res_data, res_v, exps[i]);
            end
            release_res();
        end
    endtask

    task automatic test_backpressure();
        accept(4'd2, 16'h0F0F, 16'h00FF);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 4'd0; req_x = 16'h1111; req_y = 16'h1111;
            checks++;
            if (res_valid !== 1'b1 || res_data !== 16'h000F || req_ready !== 1'b0 || res_v !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: valid=%b data=%h ready=%b v=%b required 1 000f 0 0", i, res_valid, res_data, req_ready, res_v);
            end
        end
        req_valid = 1'b0;
        release_res();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_release: valid=%b ready=%b required 0 1", res_valid, req_ready);
        end
    endtask

    task automatic test_illegal();
        accept(4'hC, 16'hAAAA, 16'h5555);
        @(negedge clk);
        checks++;
        if (alu_fn !== 2'b00 || inv_x !== 1'b0 || inv_y !== 1'b0 || alu_cin !== 1'b0) begin
            failures++;
            $display("FAIL illegal_p1: fn=%b inv=%b%b cin=%b required 00 00 0", alu_fn, inv_x, inv_y, alu_cin);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 16'h0000 || res_v !== 1'b0) begin
            failures++;
            $display("FAIL illegal_result: valid=%b err=%b data=%h v=%b required 1 1 0000 0", res_valid, res_err, res_data, res_v);
        end
        release_res();
        @(negedge clk);
        checks++;
        if (res_err !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear: err=%b valid=%b required 0 0", res_err, res_valid);
        end
    endtask

    task automatic test_reset_mid();
        accept(4'd8, 16'h8000, 16'h0001);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, res_valid, res_err, res_v, res_data, alu_x, alu_y, inv_x, inv_y, alu_cin, alu_fn} !== {1'b1, 56'd0}) begin
            failures++;
            $display("FAIL reset_mid: ready=%b valid=%b data=%h alu_x=%h fn=%b required ready=1 rest 0",
                     req_ready, res_valid, res_data, alu_x, alu_fn);
        end
        @(negedge clk); rst_n = 1'b1;
        accept(4'd0, 16'h1234, 16'h0001);
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h1235 || res_v !== 1'b0) begin
            failures++;
            $display("FAIL add_after_reset: valid=%b data=%h v=%b required 1 1235 0", res_valid, res_data, res_v);
        end
        release_res();
    endtask

    task automatic test_back_to_back();
        accept(4'd6, 16'hFFFF, 16'h00FF);
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'hFF00) begin
            failures++;
            $display("FAIL andn_result: valid=%b data=%h required 1 ff00", res_valid, res_data);
        end
        // Response handshake with the next request already pending
        res_ready = 1'b1;
        req_valid = 1'b1; req_op = 4'd5; req_x = 16'h0FF0; req_y = 16'h00FF;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: ready=%b valid=%b required 1 0", req_ready, res_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || alu_fn !== 2'b10 || inv_x !== 1'b1 || inv_y !== 1'b1) begin
            failures++;
            $display("FAIL b2b_p1: ready=%b fn=%b inv=%b%b required 0 10 11", req_ready, alu_fn, inv_x, inv_y);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'hFF0F) begin
            failures++;
            $display("FAIL nand_result: valid=%b data=%h required 1 ff0f", res_valid, res_data);
        end
        release_res();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_nor();
        test_abs();
        test_minmax();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
